cpu7_ifu_ibuf: RTL and testbench
================================

CPU7_IFU_IBUF -- requirements
Module: cpu7_ifu_ibuf

Interface
REQ-001 Parameter: DEPTH, 4, number of instruction entries; power of two, 2..8.
REQ-002 Parameter: PTR_W, 2, log2(DEPTH), width of read/write pointers.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 fet_ibuf_valid  input  1  fetch side offers an instruction this cycle.
REQ-006 fet_ibuf_pc  input  `GRLEN  PC of offered instruction.
REQ-007 fet_ibuf_inst  input  32  instruction word.
REQ-008 fet_ibuf_exception  input  1  fetch-side exception flag (e.g. ADEF/TLB).
REQ-009 fet_ibuf_exccode  input  6  exception code, meaningful only with the exception flag.
REQ-010 ibuf_fet_ready  output  1  buffer accepts a push this cycle.
REQ-011 ibuf_dec_valid  output  1  head entry is valid for decode.
REQ-012 ibuf_dec_pc  output  `GRLEN  head PC.
REQ-013 ibuf_dec_inst  output  32  head instruction.
REQ-014 ibuf_dec_exception  output  1  head exception flag.
REQ-015 ibuf_dec_exccode  output  6  head exception code.
REQ-016 dec_ibuf_ready  input  1  decode consumes head this cycle; driven low by top level while exu_ifu_stall_req is high.
REQ-017 exu_ifu_br_taken_e  input  1  taken branch resolved in E; flush request.
REQ-018 ibuf_count  output  PTR_W+1  current occupancy, 0..DEPTH.

Function
REQ-019 Push occurs when fet_ibuf_valid && ibuf_fet_ready && !exu_ifu_br_taken_e; the entry {pc, inst, exception, exccode} is written at wptr, and wptr increments modulo DEPTH.
REQ-020 Pop occurs when ibuf_dec_valid && dec_ibuf_ready && !exu_ifu_br_taken_e; rptr increments modulo DEPTH.
REQ-021 ibuf_fet_ready = (count != DEPTH); it is combinational from registered count only and has no pop-bypass.
REQ-022 ibuf_dec_valid = (count != 0); there is no empty-bypass, so push-to-valid latency is exactly 1 cycle.
REQ-023 Simultaneous push and pop leaves count unchanged while both pointers advance.
REQ-024 Count rules: +1 on push only, -1 on pop only, unchanged otherwise; it never exceeds DEPTH and never underflows.
REQ-025 Flush: when exu_ifu_br_taken_e=1, the next state is count=0, wptr=rptr=0; the same-cycle push and pop are both suppressed, with flush taking priority.
REQ-026 Flush on an empty or full buffer behaves identically to REQ-025.
REQ-027 Head data outputs are driven combinationally from the entry at rptr when ibuf_dec_valid=1, and are forced to all-zero when ibuf_dec_valid=0.
REQ-028 Entries are consumed strictly in FIFO order; the exception flag and exccode travel with their own entry unchanged.
REQ-029 fet_ibuf_valid=1 while ready=0 causes no state change; the fetch side holds or reissues the instruction.
REQ-030 Pointer wrap: after DEPTH pushes, wptr returns to 0; full versus empty is distinguished by count, not by pointer compare.

Reset
REQ-031 Assertion of reset immediately and asynchronously forces count=0, wptr=0, rptr=0, so that ibuf_dec_valid=0, ibuf_fet_ready=1, ibuf_count=0, and all head data outputs are 0.
REQ-032 Entry storage is not reset.
REQ-033 Reset mid-operation discards all buffered entries; the first push after deassertion lands at index 0.

Structure
REQ-034 `GRLEN and the default DEPTH constant (`CPU7_IBUF_DEPTH) SHALL reside in common.vh; the module SHALL define no local copy of `GRLEN.
REQ-035 The module has no sub-module; storage is an inline register array of DEPTH x (`GRLEN+32+1+6) bits.
REQ-036 The module sits between instruction fetch and the decode that produces the ifu_exu_*_d signals; cpu7_ifu instantiates it.

Verification
REQ-037 Reset, then push pc=0x1c000000 inst=0x02800421 -> valid=0 in the push cycle, valid=1 in the next cycle with the same pc/inst and count=1.
REQ-038 Hold dec_ibuf_ready=0 and push 5 consecutive instructions -> count reaches 4 and ready=0 on the 5th; the 5th is not stored; releasing ready pops in order 0x..00, 04, 08, 0c.
REQ-039 With count=2, push and pop in the same cycle -> count stays 2 and head advances to the next PC.
REQ-040 With count=3, assert exu_ifu_br_taken_e together with a push -> next cycle count=0, valid=0, and outputs are zero; a push one cycle later is at index 0.
REQ-041 Push an entry with exception=1, exccode=0x08 between two normal entries -> it pops second with exception=1 and exccode=0x08, and its neighbours have exception=0.
REQ-042 Assert reset asynchronously mid-cycle with count=4 -> outputs reach their reset values before the next clock edge, with ready=1 and count=0.

Source files
------------

// File: rtl/cpu7_ifu_ibuf_pkg.sv
// Shared types for the IFU instruction buffer: entry layout and core widths.
// `GRLEN / `CPU7_IBUF_DEPTH normally arrive from common.vh; the fallbacks keep this slice standalone.
`ifndef GRLEN
`define GRLEN 32
`endif
`ifndef CPU7_IBUF_DEPTH
`define CPU7_IBUF_DEPTH 4
`endif

package cpu7_ifu_ibuf_pkg;

  localparam int GRLEN        = `GRLEN;
  localparam int IBUF_DEPTH   = `CPU7_IBUF_DEPTH;
  localparam int IBUF_ENTRY_W = GRLEN + 32 + 1 + 6;

  typedef struct packed {
    logic [GRLEN-1:0] pc;
    logic [31:0]      inst;
    logic             exception;
    logic [5:0]       exccode;
  } ibuf_entry_t;

  // Head data is zeroed whenever the buffer has nothing to offer decode.
  function automatic ibuf_entry_t mask_entry(input ibuf_entry_t e, input logic keep);
    return keep ? e : '0;
  endfunction

endpackage

// File: rtl/cpu7_ifu_ibuf.sv
// Instruction buffer between fetch and decode: DEPTH-entry FIFO of {pc, inst, exception, exccode}.
// A taken branch in E flushes the whole buffer and overrides any push/pop in the same cycle.
module cpu7_ifu_ibuf
  import cpu7_ifu_ibuf_pkg::*;
#(
  parameter int DEPTH = IBUF_DEPTH,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fet_ibuf_valid,
  input  logic [GRLEN-1:0] fet_ibuf_pc,
  input  logic [31:0]      fet_ibuf_inst,
  input  logic             fet_ibuf_exception,
  input  logic [5:0]       fet_ibuf_exccode,
  output logic             ibuf_fet_ready,
  output logic             ibuf_dec_valid,
  output logic [GRLEN-1:0] ibuf_dec_pc,
  output logic [31:0]      ibuf_dec_inst,
  output logic             ibuf_dec_exception,
  output logic [5:0]       ibuf_dec_exccode,
  input  logic             dec_ibuf_ready,
  input  logic             exu_ifu_br_taken_e,
  output logic [PTR_W:0]   ibuf_count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  ibuf_entry_t      mem [DEPTH];
  ibuf_entry_t      head;
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [PTR_W:0]   count;
  logic             push;
  logic             pop;

  // Full/empty come from the registered count only, so ready never depends on pop.
  assign ibuf_fet_ready = (count != FULL_CNT);
  assign ibuf_dec_valid = (count != '0);
  assign ibuf_count     = count;

  assign push = fet_ibuf_valid & ibuf_fet_ready & ~exu_ifu_br_taken_e;
  assign pop  = ibuf_dec_valid & dec_ibuf_ready & ~exu_ifu_br_taken_e;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (exu_ifu_br_taken_e) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= '{pc:        fet_ibuf_pc,
                     inst:      fet_ibuf_inst,
                     exception: fet_ibuf_exception,
                     exccode:   fet_ibuf_exccode};
    end
  end

  assign head               = mask_entry(mem[rptr], ibuf_dec_valid);
  assign ibuf_dec_pc        = head.pc;
  assign ibuf_dec_inst      = head.inst;
  assign ibuf_dec_exception = head.exception;
  assign ibuf_dec_exccode   = head.exccode;

endmodule

// File: tb/tb_cpu7_ifu_ibuf.sv
// Directed bench for cpu7_ifu_ibuf: latency, full/backpressure, push+pop, flush, exceptions, async reset.
module tb_cpu7_ifu_ibuf;
  import cpu7_ifu_ibuf_pkg::*;

  logic             clk;
  logic             reset;
  logic             fet_ibuf_valid;
  logic [GRLEN-1:0] fet_ibuf_pc;
  logic [31:0]      fet_ibuf_inst;
  logic             fet_ibuf_exception;
  logic [5:0]       fet_ibuf_exccode;
  logic             ibuf_fet_ready;
  logic             ibuf_dec_valid;
  logic [GRLEN-1:0] ibuf_dec_pc;
  logic [31:0]      ibuf_dec_inst;
  logic             ibuf_dec_exception;
  logic [5:0]       ibuf_dec_exccode;
  logic             dec_ibuf_ready;
  logic             exu_ifu_br_taken_e;
  logic [2:0]       ibuf_count;

  int checks = 0;
  int errors = 0;

  cpu7_ifu_ibuf #(.DEPTH(4), .PTR_W(2)) dut (
    .clk                (clk),
    .reset              (reset),
    .fet_ibuf_valid     (fet_ibuf_valid),
    .fet_ibuf_pc        (fet_ibuf_pc),
    .fet_ibuf_inst      (fet_ibuf_inst),
    .fet_ibuf_exception (fet_ibuf_exception),
    .fet_ibuf_exccode   (fet_ibuf_exccode),
    .ibuf_fet_ready     (ibuf_fet_ready),
    .ibuf_dec_valid     (ibuf_dec_valid),
    .ibuf_dec_pc        (ibuf_dec_pc),
    .ibuf_dec_inst      (ibuf_dec_inst),
    .ibuf_dec_exception (ibuf_dec_exception),
    .ibuf_dec_exccode   (ibuf_dec_exccode),
    .dec_ibuf_ready     (dec_ibuf_ready),
    .exu_ifu_br_taken_e (exu_ifu_br_taken_e),
    .ibuf_count         (ibuf_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fet_ibuf_valid     = 1'b0;
    fet_ibuf_pc        = '0;
    fet_ibuf_inst      = '0;
    fet_ibuf_exception = 1'b0;
    fet_ibuf_exccode   = '0;
    dec_ibuf_ready     = 1'b0;
    exu_ifu_br_taken_e = 1'b0;
  endtask

  task automatic push_one(input logic [31:0] pc, input logic [31:0] inst,
                          input logic exc, input logic [5:0] code);
    fet_ibuf_valid     = 1'b1;
    fet_ibuf_pc        = GRLEN'(pc);
    fet_ibuf_inst      = inst;
    fet_ibuf_exception = exc;
    fet_ibuf_exccode   = code;
    step();
    fet_ibuf_valid     = 1'b0;
    fet_ibuf_exception = 1'b0;
    fet_ibuf_exccode   = '0;
  endtask

  task automatic flush_one();
    exu_ifu_br_taken_e = 1'b1;
    step();
    exu_ifu_br_taken_e = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    #2 reset = 1'b1;
    #2;
    checks++;
    if (ibuf_dec_valid !== 1'b0 || ibuf_fet_ready !== 1'b1 || ibuf_count !== 3'd0) begin
      errors++;
      $display("FAIL reset_ctrl: valid=%b ready=%b count=%0d, want 0 1 0", ibuf_dec_valid, ibuf_fet_ready, ibuf_count);
    end
    checks++;
    if (ibuf_dec_pc !== '0 || ibuf_dec_inst !== 32'h0 || ibuf_dec_exception !== 1'b0 || ibuf_dec_exccode !== 6'h0) begin
      errors++;
      $display("FAIL reset_data: pc=%h inst=%h exc=%b code=%h, want all zero", ibuf_dec_pc, ibuf_dec_inst, ibuf_dec_exception, ibuf_dec_exccode);
    end
    @(negedge clk);
    reset = 1'b0;
    step();
  endtask

  task automatic test_push_latency();
    fet_ibuf_valid = 1'b1;
    fet_ibuf_pc    = GRLEN'(32'h1c00_0000);
    fet_ibuf_inst  = 32'h0280_0421;
    #1;
    checks++;
    if (ibuf_dec_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_push_cycle: valid=%b, want 0", ibuf_dec_valid);
    end
    step();
    fet_ibuf_valid = 1'b0;
    checks++;
    if (ibuf_dec_valid !== 1'b1 || ibuf_dec_pc !== GRLEN'(32'h1c00_0000) ||
        ibuf_dec_inst !== 32'h0280_0421 || ibuf_count !== 3'd1) begin
      errors++;
      $display("FAIL latency_next_cycle: valid=%b pc=%h inst=%h count=%0d, want 1 1c000000 02800421 1",
               ibuf_dec_valid, ibuf_dec_pc, ibuf_dec_inst, ibuf_count);
    end
    dec_ibuf_ready = 1'b1;
    step();
    dec_ibuf_ready = 1'b0;
    checks++;
    if (ibuf_count !== 3'd0 || ibuf_dec_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_drain: count=%0d valid=%b, want 0 0", ibuf_count, ibuf_dec_valid);
    end
  endtask

  task automatic test_full();
    logic [31:0] base;
    base = 32'h1c00_0100;
    dec_ibuf_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        #1;
        checks++;
        if (ibuf_fet_ready !== 1'b0 || ibuf_count !== 3'd4) begin
          errors++;
          $display("FAIL full_ready: ready=%b count=%0d, want 0 4", ibuf_fet_ready, ibuf_count);
        end
      end
      push_one(base + 32'(4 * i), 32'h0010_0000 + 32'(i), 1'b0, 6'h0);
    end
    checks++;
    if (ibuf_count !== 3'd4 || ibuf_dec_pc !== GRLEN'(base)) begin
      errors++;
      $display("FAIL full_hold: count=%0d head=%h, want 4 %h", ibuf_count, ibuf_dec_pc, base);
    end
    dec_ibuf_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ibuf_dec_valid !== 1'b1 || ibuf_dec_pc !== GRLEN'(base + 32'(4 * i)) ||
          ibuf_dec_inst !== 32'h0010_0000 + 32'(i)) begin
        errors++;
        $display("FAIL full_pop_order[%0d]: valid=%b pc=%h inst=%h, want 1 %h %h",
                 i, ibuf_dec_valid, ibuf_dec_pc, ibuf_dec_inst, base + 32'(4 * i), 32'h0010_0000 + 32'(i));
      end
      step();
    end
    dec_ibuf_ready = 1'b0;
    checks++;
    if (ibuf_count !== 3'd0 || ibuf_dec_valid !== 1'b0 || ibuf_dec_pc !== '0 || ibuf_fet_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_empty_after: count=%0d valid=%b pc=%h ready=%b, want 0 0 0 1",
               ibuf_count, ibuf_dec_valid, ibuf_dec_pc, ibuf_fet_ready);
    end
  endtask

  task automatic test_back_to_back();
    push_one(32'h1c00_00a0, 32'h0000_00a0, 1'b0, 6'h0);
    push_one(32'h1c00_00a4, 32'h0000_00a4, 1'b0, 6'h0);
    dec_ibuf_ready = 1'b1;
    push_one(32'h1c00_00a8, 32'h0000_00a8, 1'b0, 6'h0);
    dec_ibuf_ready = 1'b0;
    checks++;
    if (ibuf_count !== 3'd2 || ibuf_dec_pc !== GRLEN'(32'h1c00_00a4) || ibuf_dec_inst !== 32'h0000_00a4) begin
      errors++;
      $display("FAIL push_pop_same_cycle: count=%0d head=%h inst=%h, want 2 1c0000a4 000000a4",
               ibuf_count, ibuf_dec_pc, ibuf_dec_inst);
    end
    flush_one();
  endtask

  task automatic test_flush();
    push_one(32'h1c00_00b0, 32'h0000_00b0, 1'b0, 6'h0);
    push_one(32'h1c00_00b4, 32'h0000_00b4, 1'b0, 6'h0);
    push_one(32'h1c00_00b8, 32'h0000_00b8, 1'b0, 6'h0);
    fet_ibuf_valid     = 1'b1;
    fet_ibuf_pc        = GRLEN'(32'h1c00_00bc);
    fet_ibuf_inst      = 32'h0000_00bc;
    dec_ibuf_ready     = 1'b1;
    exu_ifu_br_taken_e = 1'b1;
    step();
    fet_ibuf_valid     = 1'b0;
    dec_ibuf_ready     = 1'b0;
    exu_ifu_br_taken_e = 1'b0;
    checks++;
    if (ibuf_count !== 3'd0 || ibuf_dec_valid !== 1'b0 || ibuf_dec_pc !== '0 || ibuf_dec_inst !== 32'h0) begin
      errors++;
      $display("FAIL flush_clear: count=%0d valid=%b pc=%h inst=%h, want 0 0 0 0",
               ibuf_count, ibuf_dec_valid, ibuf_dec_pc, ibuf_dec_inst);
    end
    push_one(32'h1c00_00c0, 32'h0000_00c0, 1'b0, 6'h0);
    checks++;
    if (ibuf_count !== 3'd1 || ibuf_dec_pc !== GRLEN'(32'h1c00_00c0) || ibuf_dec_inst !== 32'h0000_00c0) begin
      errors++;
      $display("FAIL flush_restart: count=%0d head=%h inst=%h, want 1 1c0000c0 000000c0",
               ibuf_count, ibuf_dec_pc, ibuf_dec_inst);
    end
    // Flush on a full buffer
    push_one(32'h1c00_00c4, 32'h0, 1'b0, 6'h0);
    push_one(32'h1c00_00c8, 32'h0, 1'b0, 6'h0);
    push_one(32'h1c00_00cc, 32'h0, 1'b0, 6'h0);
    flush_one();
    checks++;
    if (ibuf_count !== 3'd0 || ibuf_fet_ready !== 1'b1 || ibuf_dec_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_full: count=%0d ready=%b valid=%b, want 0 1 0", ibuf_count, ibuf_fet_ready, ibuf_dec_valid);
    end
  endtask

  task automatic test_exception();
    logic [31:0] pcs   [3];
    logic        excs  [3];
    logic [5:0]  codes [3];
    pcs   = '{32'h1c00_00d0, 32'h1c00_00d4, 32'h1c00_00d8};
    excs  = '{1'b0, 1'b1, 1'b0};
    codes = '{6'h00, 6'h08, 6'h00};
    for (int i = 0; i < 3; i++) push_one(pcs[i], 32'h0000_0d00 + 32'(i), excs[i], codes[i]);
    dec_ibuf_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ibuf_dec_pc !== GRLEN'(pcs[i]) || ibuf_dec_exception !== excs[i] || ibuf_dec_exccode !== codes[i]) begin
        errors++;
        $display("FAIL exception_pop[%0d]: pc=%h exc=%b code=%h, want %h %b %h",
                 i, ibuf_dec_pc, ibuf_dec_exception, ibuf_dec_exccode, pcs[i], excs[i], codes[i]);
      end
      step();
    end
    dec_ibuf_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) push_one(32'h1c00_00e0 + 32'(4 * i), 32'h0000_0e00, 1'b0, 6'h0);
    checks++;
    if (ibuf_count !== 3'd4) begin
      errors++;
      $display("FAIL async_prefill: count=%0d, want 4", ibuf_count);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (ibuf_fet_ready !== 1'b1 || ibuf_count !== 3'd0 || ibuf_dec_valid !== 1'b0 || ibuf_dec_pc !== '0) begin
      errors++;
      $display("FAIL async_reset: ready=%b count=%0d valid=%b pc=%h, want 1 0 0 0",
               ibuf_fet_ready, ibuf_count, ibuf_dec_valid, ibuf_dec_pc);
    end
    @(negedge clk);
    reset = 1'b0;
    step();
    push_one(32'h1c00_00f0, 32'h0000_00f0, 1'b0, 6'h0);
    checks++;
    if (ibuf_count !== 3'd1 || ibuf_dec_pc !== GRLEN'(32'h1c00_00f0) || ibuf_dec_inst !== 32'h0000_00f0) begin
      errors++;
      $display("FAIL reset_restart: count=%0d head=%h inst=%h, want 1 1c0000f0 000000f0",
               ibuf_count, ibuf_dec_pc, ibuf_dec_inst);
    end
  endtask

  initial begin
    test_reset();
    test_push_latency();
    test_full();
    test_back_to_back();
    test_flush();
    test_exception();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
